pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage MIPS32 datapath. It tracks one valid bit per pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB). It generates the per-stage `allow_in` handshakes that gate those registers, and it drives the `cancel` flush line they consume. `cancel` is held until fetch accepts the exception redirect (`if_addr_ok`). The block also keeps a retired-instruction counter.

---
 rtl/pipe_pkg.sv | 23 ++
 rtl/pipe_ctrl_stage_valid_reg.sv | 35 +++
 rtl/pipe_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ============================================================================
// Module : pipe_pkg
// Brief  : Shared state encoding and stage indices for the pipeline controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam int unsigned ID         = 0;
    localparam int unsigned EX         = 1;
    localparam int unsigned MEM        = 2;
    localparam int unsigned WB         = 3;
    localparam int unsigned NUM_STAGES = 4;

endpackage

`default_nettype wire

// File: rtl/pipe_ctrl_stage_valid_reg.sv
// ============================================================================
// Module : stage_valid_reg
// Brief  : Valid bit of one pipeline register; flush beats load beats drain.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module stage_valid_reg (
    input  logic clk,
    input  logic reset,
    input  logic in_fire,
    input  logic out_fire,
    input  logic flush,
    output logic valid
);

    logic r_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (in_fire) begin
            r_valid <= 1'b1;
        end else if (out_fire) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;

endmodule

`default_nettype wire

// File: rtl/pipe_ctrl.sv
// ============================================================================
// Module : pipe_ctrl
// Brief  : Five-stage pipeline handshake, exception flush and retire counter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IF_over,
    input  logic             ID_over,
    input  logic             EX_over,
    input  logic             MEM_over,
    input  logic             WB_over,
    input  logic             WB_exc,
    input  logic             if_addr_ok,
    output logic             ID_allow_in,
    output logic             EX_allow_in,
    output logic             MEM_allow_in,
    output logic             WB_allow_in,
    output logic             cancel,
    output logic [3:0]       stage_valid,
    output logic [CNT_W-1:0] retired
);

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_retired;
    logic [3:0]       w_valid;
    logic [3:0]       w_over;
    logic [3:0]       w_chain;
    logic [3:0]       w_allow;
    logic [3:0]       w_in_fire;
    logic [3:0]       w_out_fire;
    logic             w_commit;
    logic             w_exc_commit;
    logic             w_open;
    logic             w_flush;

    assign w_over = {WB_over, MEM_over, EX_over, ID_over};

    // Back-pressure chain, resolved from WB toward ID in one cycle.
    always_comb begin
        w_chain     = '0;
        w_chain[WB] = ~w_valid[WB] | WB_over;
        for (int s = int'(MEM); s >= int'(ID); s--) begin
            w_chain[s] = ~w_valid[s] | (w_over[s] & w_chain[s+1]);
        end
    end

    assign w_commit     = (r_state == RUN) & w_valid[WB] & WB_over;
    assign w_exc_commit = w_commit & WB_exc;
    // Freeze on exception commit and throughout the flush; if_addr_ok stays out.
    assign w_open       = (r_state == RUN) & ~w_exc_commit;
    assign w_allow      = w_chain & {4{w_open}};
    assign w_flush      = cancel & if_addr_ok;

    always_comb begin
        w_in_fire      = '0;
        w_out_fire     = '0;
        w_in_fire[ID]  = IF_over & w_allow[ID];
        for (int s = int'(ID); s < int'(WB); s++) begin
            w_in_fire[s+1] = w_valid[s] & w_over[s] & w_allow[s+1];
            w_out_fire[s]  = w_in_fire[s+1];
        end
        w_out_fire[WB] = w_commit;
    end

    generate
        for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
            stage_valid_reg u_valid (
                .clk      (clk),
                .reset    (reset),
                .in_fire  (w_in_fire[g]),
                .out_fire (w_out_fire[g]),
                .flush    (w_flush),
                .valid    (w_valid[g])
            );
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RUN:     if (w_exc_commit) w_state_next = FLUSH;
            FLUSH:   if (if_addr_ok)   w_state_next = RUN;
            default: w_state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_retired <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_commit && !WB_exc) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign cancel       = (r_state == FLUSH);
    assign ID_allow_in  = w_allow[ID];
    assign EX_allow_in  = w_allow[EX];
    assign MEM_allow_in = w_allow[MEM];
    assign WB_allow_in  = w_allow[WB];
    assign stage_valid  = w_valid;
    assign retired      = r_retired;

endmodule

`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// ============================================================================
// Module : tb_pipe_ctrl
// Brief  : Directed vector table, counter wrap and randomized model checking.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset, IF_over, ID_over, EX_over, MEM_over, WB_over, WB_exc, if_addr_ok;
    logic        ID_allow_in, EX_allow_in, MEM_allow_in, WB_allow_in, cancel;
    logic        ID_allow_in4, EX_allow_in4, MEM_allow_in4, WB_allow_in4, cancel4;
    logic [3:0]  stage_valid, stage_valid4;
    logic [31:0] retired;
    logic [3:0]  retired4;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .IF_over(IF_over), .ID_over(ID_over),
        .EX_over(EX_over), .MEM_over(MEM_over), .WB_over(WB_over), .WB_exc(WB_exc),
        .if_addr_ok(if_addr_ok), .ID_allow_in(ID_allow_in), .EX_allow_in(EX_allow_in),
        .MEM_allow_in(MEM_allow_in), .WB_allow_in(WB_allow_in), .cancel(cancel),
        .stage_valid(stage_valid), .retired(retired)
    );

    pipe_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .IF_over(IF_over), .ID_over(ID_over),
        .EX_over(EX_over), .MEM_over(MEM_over), .WB_over(WB_over), .WB_exc(WB_exc),
        .if_addr_ok(if_addr_ok), .ID_allow_in(ID_allow_in4), .EX_allow_in(EX_allow_in4),
        .MEM_allow_in(MEM_allow_in4), .WB_allow_in(WB_allow_in4), .cancel(cancel4),
        .stage_valid(stage_valid4), .retired(retired4)
    );

    // Behavioural reference: occupancy array, flushing flag, integer counter.
    bit          m_occ [4];
    bit          m_flushing;
    longint      m_count;

    function automatic logic [3:0] model_allow();
        bit ov [4];
        bit al [4];
        logic [3:0] r;
        ov[0] = ID_over; ov[1] = EX_over; ov[2] = MEM_over; ov[3] = WB_over;
        al[3] = !m_occ[3] || ov[3];
        for (int s = 2; s >= 0; s--) al[s] = !m_occ[s] || (ov[s] && al[s+1]);
        for (int s = 0; s < 4; s++) r[s] = al[s];
        if (m_flushing || (m_occ[3] && WB_over && WB_exc)) r = 4'b0000;
        return r;
    endfunction

    task automatic model_tick();
        logic [3:0] al;
        bit ov [4];
        bit into [5];
        bit nocc [4];
        if (reset) begin
            foreach (m_occ[s]) m_occ[s] = 0;
            m_flushing = 0;
            m_count    = 0;
        end else if (m_flushing) begin
            if (if_addr_ok) begin
                foreach (m_occ[s]) m_occ[s] = 0;
                m_flushing = 0;
            end
        end else begin
            al = model_allow();
            ov[0] = ID_over; ov[1] = EX_over; ov[2] = MEM_over; ov[3] = WB_over;
            into[0] = IF_over && al[0];
            for (int s = 0; s < 3; s++) into[s+1] = m_occ[s] && ov[s] && al[s+1];
            into[4] = m_occ[3] && WB_over;
            for (int s = 0; s < 4; s++) nocc[s] = into[s] || (m_occ[s] && !into[s+1]);
            if (into[4]) begin
                if (WB_exc) m_flushing = 1;
                else        m_count++;
            end
            foreach (m_occ[s]) m_occ[s] = nocc[s];
        end
    endtask

    function automatic logic [3:0] model_valid();
        logic [3:0] r;
        for (int s = 0; s < 4; s++) r[s] = m_occ[s];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic r, input logic [4:0] ov, input logic e, input logic k);
        reset = r; IF_over = ov[0]; ID_over = ov[1]; EX_over = ov[2];
        MEM_over = ov[3]; WB_over = ov[4]; WB_exc = e; if_addr_ok = k;
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        model_tick();
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic [4:0]  ov;     // {WB, MEM, EX, ID, IF}
        logic        exc;
        logic        ok;
        logic        chk;
        logic [3:0]  allow;  // {WB, MEM, EX, ID}
        logic        cncl;
        logic [3:0]  valid;
        logic [31:0] ret;
    } vec_t;

    vec_t vq[$];

    task automatic row(input logic r, input logic [4:0] ov, input logic e, input logic k,
                       input logic c, input logic [3:0] al, input logic cn,
                       input logic [3:0] v, input logic [31:0] rt);
        vec_t x;
        x.rst = r; x.ov = ov; x.exc = e; x.ok = k; x.chk = c;
        x.allow = al; x.cncl = cn; x.valid = v; x.ret = rt;
        vq.push_back(x);
    endtask

    task automatic check_all(input string tag, input logic [3:0] al, input logic cn,
                             input logic [3:0] v, input logic [31:0] rt);
        check({tag, " allow"}, {28'd0, WB_allow_in, MEM_allow_in, EX_allow_in, ID_allow_in}, {28'd0, al});
        check({tag, " cancel"}, {31'd0, cancel}, {31'd0, cn});
        check({tag, " valid"}, {28'd0, stage_valid}, {28'd0, v});
        check({tag, " retired"}, retired, rt);
        check({tag, " retired4"}, {28'd0, retired4}, {28'd0, rt[3:0]});
    endtask

    initial begin
        // Reset then stream
        row(1, 5'h1F, 0, 0, 0, 4'hF, 0, 4'b0000, 0);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0000, 0);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0001, 0);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0011, 0);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0111, 0);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b1111, 0);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b1111, 1);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b1111, 2);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b1111, 3);
        // MEM stall for three cycles
        row(0, 5'h17, 0, 0, 1, 4'b1000, 0, 4'b1111, 4);
        row(0, 5'h17, 0, 0, 1, 4'b1000, 0, 4'b0111, 5);
        row(0, 5'h17, 0, 0, 1, 4'b1000, 0, 4'b0111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF,    0, 4'b0111, 5);
        // Exception with delayed redirect
        row(0, 5'h1F, 1, 0, 1, 4'h0, 0, 4'b1111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 1, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0000, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0001, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0011, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0111, 5);
        // Immediate redirect
        row(0, 5'h1F, 1, 1, 1, 4'h0, 0, 4'b1111, 5);
        row(0, 5'h1F, 0, 1, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 1, 1, 4'hF, 0, 4'b0000, 5);
        row(0, 5'h1F, 0, 1, 1, 4'hF, 0, 4'b0001, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0011, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0111, 5);
        // Reset mid-flush
        row(0, 5'h1F, 1, 0, 1, 4'h0, 0, 4'b1111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'h0, 1, 4'b0111, 5);
        row(1, 5'h1F, 0, 0, 1, 4'h0, 1, 4'b0111, 5);
        row(0, 5'h1F, 0, 0, 1, 4'hF, 0, 4'b0000, 0);

        @(negedge clk);
        foreach (vq[i]) begin
            apply(vq[i].rst, vq[i].ov, vq[i].exc, vq[i].ok);
            if (vq[i].chk) check_all($sformatf("vec%0d", i), vq[i].allow, vq[i].cncl, vq[i].valid, vq[i].ret);
            advance();
        end

        // Counter wrap: 17 clean commits need 4 fill edges plus 17 commit edges
        apply(1, 5'h1F, 0, 0);
        advance();
        for (int c = 0; c < 21; c++) begin
            apply(0, 5'h1F, 0, 0);
            advance();
        end
        apply(0, 5'h1F, 0, 0);
        check("wrap retired4", {28'd0, retired4}, 32'd1);
        check("wrap retired", retired, 32'd17);

        // Randomized run against the reference model
        apply(1, 5'h00, 0, 0);
        advance();
        for (int c = 0; c < 3000; c++) begin
            logic [4:0] ov;
            for (int b = 0; b < 5; b++) ov[b] = ($urandom_range(0, 3) != 0);
            apply(($urandom_range(0, 150) == 0), ov, ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 2) == 0));
            check_all($sformatf("rnd%0d", c), model_allow(), m_flushing, model_valid(),
                      m_count[31:0]);
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
